// File: rtl/regfile_sched_pkg.sv
// Shared types and sizes for the register-file write-port scheduler.
// Imported by the scheduler top and its address decoder.
package regfile_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int NREGS   = 32;
    localparam int RADDR_W = 5;
    localparam int RDATA_W = 32;
    localparam int WAIT_W  = 4;

    localparam logic [NREGS-1:0]   REG0_MASK = {{(NREGS-1){1'b1}}, 1'b0};
    localparam logic [RADDR_W-1:0] PTR_FIRST = RADDR_W'(1);
    localparam logic [RADDR_W-1:0] PTR_LAST  = RADDR_W'(NREGS-1);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/regfile_wr_sched_dec.sv
// 5-to-32 one-hot write-address decoder for the register file.
// Purely combinational; enable gating is done by the caller.
module Decoder5_32
    import regfile_sched_pkg::*;
(
    input  logic [RADDR_W-1:0] addr_i,
    output logic [NREGS-1:0]   onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Shares the register-file write port between core writeback (A) and
// debug/loader (B), and runs a clear sweep over r1..r31.
module regfile_wr_sched
    import regfile_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter bit          SWEEP_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_start,
    input  logic               a_we,
    input  logic [RADDR_W-1:0] a_addr,
    input  logic [RDATA_W-1:0] a_data,
    output logic               a_stall,
    input  logic               b_req,
    input  logic [RADDR_W-1:0] b_addr,
    input  logic [RDATA_W-1:0] b_data,
    output logic               b_ack,
    output logic               busy,
    output logic [NREGS-1:0]   rf_we,
    output logic [RADDR_W-1:0] rf_addr,
    output logic [RDATA_W-1:0] rf_data
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
    localparam state_t RST_STATE = SWEEP_ON_RESET ? SWEEP : IDLE;

    state_t             state_q, state_d;
    logic [RADDR_W-1:0] ptr_q, ptr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic               b_grant;
    logic               a_grant;
    logic               wr_valid;
    logic [RADDR_W-1:0] sel_addr;
    logic [RDATA_W-1:0] sel_data;
    logic               sel_busy;
    logic               sel_ack;
    logic               sel_stall;
    logic [NREGS-1:0]   dec_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            ptr_q   <= PTR_FIRST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wait_d    = '0;
        b_grant   = 1'b0;
        a_grant   = 1'b0;
        wr_valid  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_busy  = 1'b0;
        sel_ack   = 1'b0;
        sel_stall = 1'b0;
        unique case (state_q)
            SWEEP: begin
                wr_valid  = 1'b1;
                sel_addr  = ptr_q;
                sel_busy  = 1'b1;
                sel_stall = a_we;
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = PTR_FIRST;
                end else begin
                    ptr_d = ptr_q + RADDR_W'(1);
                end
            end
            IDLE: begin
                b_grant   = b_req && (!a_we || wait_q >= LIMIT);
                a_grant   = !b_grant && a_we;
                wr_valid  = b_grant || a_grant;
                sel_ack   = b_grant;
                sel_stall = a_we && b_grant;
                if (b_grant) begin
                    sel_addr = b_addr;
                    sel_data = b_data;
                end else if (a_grant) begin
                    sel_addr = a_addr;
                    sel_data = a_data;
                end
                // A granted request restarts the count for any follow-on request
                if (b_req && !b_grant) begin
                    wait_d = sat_inc(wait_q);
                end
                if (init_start) begin
                    state_d = SWEEP;
                    ptr_d   = PTR_FIRST;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = PTR_FIRST;
            end
        endcase
    end

    Decoder5_32 u_dec (
        .addr_i   (rf_addr),
        .onehot_o (dec_onehot)
    );

    // Outputs are held quiet for the whole reset pulse, not just until the edge
    always_comb begin
        rf_addr = reset ? '0 : sel_addr;
        rf_data = reset ? '0 : sel_data;
        busy    = !reset && sel_busy;
        b_ack   = !reset && sel_ack;
        a_stall = !reset && sel_stall;
        rf_we   = dec_onehot & REG0_MASK & {NREGS{wr_valid && !reset}};
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed plus randomized bench for regfile_wr_sched against a
// cycle-level reference model of the write-port rules.
module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_start;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_req;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ack;
    logic        busy;
    logic [31:0] rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_sweep;
    int m_idx;
    int m_starve;
    // expected outputs for the current cycle
    bit          e_stall, e_ack, e_busy;
    logic [31:0] e_we, e_data;
    logic [4:0]  e_addr;
    bit          e_bg, e_ag;

    regfile_wr_sched #(.STARVE_LIMIT(8), .SWEEP_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_stall    (a_stall),
        .b_req      (b_req),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ack      (b_ack),
        .busy       (busy),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_sweep  = 1'b1;
        m_idx    = 1;
        m_starve = 0;
    endtask

    function automatic void predict();
        int wa;
        e_bg = 0; e_ag = 0;
        e_stall = 0; e_ack = 0; e_busy = 0;
        e_we = 0; e_addr = 0; e_data = 0;
        if (reset) return;
        if (m_sweep) begin
            e_addr  = 5'(m_idx);
            e_we    = 32'h1 << m_idx;
            e_busy  = 1;
            e_stall = a_we;
        end else begin
            e_bg = b_req && (!a_we || m_starve >= 8);
            e_ag = !e_bg && a_we;
            if (e_bg) begin
                e_addr = b_addr; e_data = b_data;
            end else if (e_ag) begin
                e_addr = a_addr; e_data = a_data;
            end
            wa = int'(e_addr);
            if ((e_bg || e_ag) && wa != 0) e_we = 32'h1 << wa;
            e_ack   = e_bg;
            e_stall = a_we && e_bg;
        end
    endfunction

    task automatic sample();
        @(negedge clk);
        predict();
        chk("rf_we", rf_we, e_we);
        chk("rf_addr", 32'(rf_addr), 32'(e_addr));
        chk("rf_data", rf_data, e_data);
        chk("b_ack", 32'(b_ack), 32'(e_ack));
        chk("a_stall", 32'(a_stall), 32'(e_stall));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic commit();
        if (!reset) begin
            if (m_sweep) begin
                m_starve = 0;
                if (m_idx == 31) begin
                    m_sweep = 0;
                    m_idx = 1;
                end else begin
                    m_idx++;
                end
            end else begin
                if (b_req && !e_bg) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                else m_starve = 0;
                if (init_start) begin
                    m_sweep = 1;
                    m_idx = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        commit();
    endtask

    task automatic idle_inputs();
        init_start = 0; a_we = 0; b_req = 0;
        a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
    endtask

    initial begin
        bit pend;
        int nbusy;
        idle_inputs();
        reset = 1;
        mreset();
        #1;
        chk("rst_we", rf_we, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;

        // power-up sweep with a core write colliding mid-way
        for (int i = 0; i < 31; i++) begin
            a_we = (i == 12);
            a_addr = 5'd9; a_data = 32'h1234;
            sample();
            chk("sweep_we", rf_we, 32'h1 << (i + 1));
            chk("sweep_busy", 32'(busy), 32'h1);
            if (i == 12) chk("sweep_stall", 32'(a_stall), 32'h1);
            commit();
        end
        a_we = 0;
        sample();
        chk("sweep_done", 32'(busy), 32'h0);
        commit();

        // plain core write
        a_we = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        sample();
        chk("a_we5", rf_we, 32'h20);
        chk("a_data5", rf_data, 32'hDEADBEEF);
        chk("a_nostall", 32'(a_stall), 32'h0);
        commit();

        // starvation: B forced ahead on the 9th contended cycle
        b_req = 1; b_addr = 5'd3; b_data = 32'hB0B0;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("starve_deny", 32'(b_ack), 32'h0);
            commit();
        end
        sample();
        chk("starve_ack", 32'(b_ack), 32'h1);
        chk("starve_we", rf_we, 32'h8);
        chk("starve_stall", 32'(a_stall), 32'h1);
        commit();
        // follow-on request restarts the count
        b_addr = 5'd4;
        sample();
        chk("restart_deny", 32'(b_ack), 32'h0);
        commit();
        idle_inputs();

        // writes to r0 are consumed with no enable
        b_req = 1; b_addr = 5'd0; b_data = 32'hFFFF;
        sample();
        chk("b0_ack", 32'(b_ack), 32'h1);
        chk("b0_we", rf_we, 32'h0);
        commit();
        b_req = 0; a_we = 1; a_addr = 5'd0; a_data = 32'h77;
        sample();
        chk("a0_we", rf_we, 32'h0);
        commit();
        idle_inputs();

        // reset mid-sweep at ptr 10
        init_start = 1;
        step();
        init_start = 0;
        for (int i = 0; i < 9; i++) step();
        sample();
        chk("pre_rst_we", rf_we, 32'h400);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_we", rf_we, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_addr", 32'(rf_addr), 32'h0);
        mreset();
        @(posedge clk); #1;
        reset = 0;
        sample();
        chk("restart_r1", rf_we, 32'h2);
        commit();
        for (int i = 0; i < 30; i++) step();

        // init_start with a core write, held through the sweep
        init_start = 1; a_we = 1; a_addr = 5'd7; a_data = 32'hA7;
        sample();
        chk("init_a7", rf_we, 32'h80);
        chk("init_busy0", 32'(busy), 32'h0);
        commit();
        a_we = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 30) init_start = 0;
            sample();
            if (busy === 1'b1) nbusy++;
            commit();
        end
        chk("one_sweep", 32'(nbusy), 32'd31);

        // randomized traffic against the model
        idle_inputs();
        pend = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                b_req = ($urandom_range(2) == 0);
                b_addr = 5'($urandom);
                b_data = $urandom;
                pend = b_req;
            end
            a_we = $urandom_range(1);
            a_addr = 5'($urandom);
            a_data = $urandom;
            init_start = ($urandom_range(59) == 0);
            sample();
            if (e_ack) pend = 0;
            commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
